// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU.
//   opcode_e : operation encodings. 4'b1010..4'b1111 have no entry and are illegal.
//   state_e  : control FSM states (IDLE, BUSY, DONE).
//   FLAG_*   : bit positions inside the 4-bit flags word {negative, zero, carry, error}.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010,
        OP_MOD = 4'b0011,
        OP_AND = 4'b0100,
        OP_CAT = 4'b0101,
        OP_EQ  = 4'b0110,
        OP_GT  = 4'b0111,
        OP_SRL = 4'b1000,
        OP_SLL = 4'b1001
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int FLAG_NEG   = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_ERR   = 0;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative multiply / modulo engine: one bit per cycle, exactly N cycles.
//   clk, rst_n : clock, asynchronous active-low reset (clears busy and counter)
//   start      : load operands and begin (ignored while busy)
//   is_mod     : 1 = restoring division (remainder), 0 = shift-add multiply
//   a, b       : operands (a is multiplier / dividend, b is multiplicand / divisor)
//   done       : high during the last iteration cycle; res_lo/res_hi carry the
//                final value in that same cycle so the caller can register it
//   res_lo     : product low word, or remainder
//   res_hi     : product high word, or 0 for modulo
module alu_iter_unit import alu_pkg::*; #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_mod,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] res_lo,
    output logic [N-1:0] res_hi
);
    localparam int CW = $clog2(N);

    logic          busy;
    logic [CW-1:0] cnt;
    logic          mode_mod;
    logic [N-1:0]  acc;    // product high half / partial remainder
    logic [N-1:0]  lo;     // multiplier shifting out / dividend-to-quotient
    logic [N-1:0]  b_r;
    logic [N-1:0]  acc_nxt;
    logic [N-1:0]  lo_nxt;
    logic [N:0]    mul_sum;
    logic [N:0]    shifted;
    logic [N:0]    trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start && !busy) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            if (cnt == CW'(N - 1)) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start && !busy) begin
            acc      <= '0;
            lo       <= a;
            b_r      <= b;
            mode_mod <= is_mod;
        end else if (busy) begin
            acc <= acc_nxt;
            lo  <= lo_nxt;
        end
    end

    always_comb begin
        mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, b_r} : '0);
        shifted = {acc, lo[N-1]};
        // Bit N of trial is the borrow: set when the shifted remainder is below the divisor.
        trial   = shifted - {1'b0, b_r};
        acc_nxt = mul_sum[N:1];
        lo_nxt  = {mul_sum[0], lo[N-1:1]};
        if (mode_mod) begin
            if (!trial[N]) begin
                acc_nxt = trial[N-1:0];
                lo_nxt  = {lo[N-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[N-1:0];
                lo_nxt  = {lo[N-2:0], 1'b0};
            end
        end
    end

    assign done   = busy && (cnt == CW'(N - 1));
    assign res_lo = mode_mod ? acc_nxt : lo_nxt;
    assign res_hi = mode_mod ? '0 : acc_nxt;

endmodule

// File: rtl/pipelined_alu.sv
// Handshaked ALU with single-cycle and N-cycle (MUL/MOD) operations.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake; opcode and operands taken on accept
//   opcode               : operation select (see alu_pkg::opcode_e)
//   operand_a, operand_b : unsigned operands
//   out_valid / out_ready: result handshake; outputs held while out_valid && !out_ready
//   result, result_hi    : low word, and high product word (0 unless MUL)
//   flags                : {negative, zero, carry, error}
module pipelined_alu import alu_pkg::*; #(
    parameter int N        = 32,
    parameter int ITER_MUL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   opcode,
    input  logic [N-1:0] operand_a,
    input  logic [N-1:0] operand_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic [3:0]   flags
);
    localparam int SW = $clog2(N);

    state_e         state, state_nxt;
    logic           accept;
    logic           op_is_iter;
    logic           iter_done;
    logic [N-1:0]   iter_lo, iter_hi;
    logic           mod_r, b_zero_r;
    logic [N-1:0]   a_r;
    logic [N-1:0]   alu_lo, alu_hi;
    logic           alu_carry, alu_err;
    logic [N:0]     add_w, sub_w;
    logic [2*N-1:0] prod_w;
    logic [SW-1:0]  shamt;

    function automatic logic [3:0] make_flags(input logic [N-1:0] r, input logic c, input logic e);
        logic [3:0] f;
        f             = '0;
        f[FLAG_NEG]   = r[N-1];
        f[FLAG_ZERO]  = (r == '0);
        f[FLAG_CARRY] = c;
        f[FLAG_ERR]   = e;
        return f;
    endfunction

    assign accept     = in_valid && in_ready;
    assign op_is_iter = (opcode == OP_MOD) || ((opcode == OP_MUL) && (ITER_MUL != 0));
    assign in_ready   = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign out_valid  = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid) state_nxt = op_is_iter ? S_BUSY : S_DONE;
            S_BUSY: if (iter_done) state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = in_valid ? (op_is_iter ? S_BUSY : S_DONE) : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    alu_iter_unit #(.N(N)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && op_is_iter),
        .is_mod (opcode == OP_MOD),
        .a      (operand_a),
        .b      (operand_b),
        .done   (iter_done),
        .res_lo (iter_lo),
        .res_hi (iter_hi)
    );

    // Single-cycle datapath, evaluated straight from the request inputs.
    always_comb begin
        add_w     = {1'b0, operand_a} + {1'b0, operand_b};
        sub_w     = {1'b0, operand_a} - {1'b0, operand_b};
        prod_w    = operand_a * operand_b;
        shamt     = operand_b[SW-1:0];
        alu_lo    = '0;
        alu_hi    = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (opcode)
            OP_ADD: begin alu_lo = add_w[N-1:0]; alu_carry = add_w[N]; end
            OP_SUB: begin alu_lo = sub_w[N-1:0]; alu_carry = sub_w[N]; end
            OP_MUL: begin
                alu_lo    = prod_w[N-1:0];
                alu_hi    = prod_w[2*N-1:N];
                alu_carry = (prod_w[2*N-1:N] != '0);
            end
            OP_MOD: alu_lo = '0;
            OP_AND: alu_lo = operand_a & operand_b;
            OP_CAT: alu_lo = {operand_a[N/2-1:0], operand_b[N/2-1:0]};
            OP_EQ:  alu_lo = N'(operand_a == operand_b);
            OP_GT:  alu_lo = N'(operand_a > operand_b);
            OP_SRL: alu_lo = operand_a >> shamt;
            OP_SLL: alu_lo = operand_a << shamt;
            default: alu_err = 1'b1;
        endcase
    end

    // Request context needed when the iterative result comes back.
    always_ff @(posedge clk) begin
        if (accept) begin
            mod_r    <= (opcode == OP_MOD);
            b_zero_r <= (operand_b == '0);
            a_r      <= operand_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
        end else if (accept && !op_is_iter) begin
            result    <= alu_lo;
            result_hi <= alu_hi;
            flags     <= make_flags(alu_lo, alu_carry, alu_err);
        end else if (iter_done) begin
            if (mod_r && b_zero_r) begin
                // Divide by zero: hand back the dividend and flag the error.
                result    <= a_r;
                result_hi <= '0;
                flags     <= make_flags(a_r, 1'b0, 1'b1);
            end else begin
                result    <= iter_lo;
                result_hi <= iter_hi;
                flags     <= make_flags(iter_lo, !mod_r && (iter_hi != '0), 1'b0);
            end
        end
    end

endmodule

// File: tb/tb_pipelined_alu.sv
module tb_pipelined_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = '0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    pipelined_alu #(.N(32), .ITER_MUL(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .result_hi(result_hi), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: plain 64-bit arithmetic straight from the opcode table.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi,
                         output logic [3:0] fl, output int lat);
        longint unsigned wa, wb, w;
        logic c, e;
        wa = a; wb = b; w = 0; c = 0; e = 0; lat = 1; hi = 0;
        case (op)
            4'd0: begin w = wa + wb; c = (w > 64'hFFFF_FFFF); end
            4'd1: begin w = (wa - wb) & 64'hFFFF_FFFF; c = (wa < wb); end
            4'd2: begin w = wa * wb; lat = 33; end
            4'd3: begin lat = 33; if (wb == 0) begin w = wa; e = 1; end else w = wa % wb; end
            4'd4: w = wa & wb;
            4'd5: w = (wa % 65536) * 65536 + (wb % 65536);
            4'd6: w = (wa == wb) ? 1 : 0;
            4'd7: w = (wa > wb) ? 1 : 0;
            4'd8: w = wa >> (wb % 32);
            4'd9: w = (wa << (wb % 32)) & 64'hFFFF_FFFF;
            default: begin w = 0; e = 1; end
        endcase
        lo = w[31:0];
        if (op == 4'd2) begin hi = w[63:32]; c = (hi != 0); end
        fl = {lo[31], lo == 0, c, e};
    endtask

    // Issue one request, measure latency, compare all outputs; optionally complete the handshake.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit release_out);
        logic [31:0] elo, ehi;
        logic [3:0]  efl;
        int          elat, lat;
        model(op, a, b, elo, ehi, efl, elat);
        @(negedge clk);
        in_valid = 1; opcode = op; operand_a = a; operand_b = b; out_ready = 0;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(elat));
        chk({tag, ".result"}, 64'(result), 64'(elo));
        chk({tag, ".result_hi"}, 64'(result_hi), 64'(ehi));
        chk({tag, ".flags"}, 64'(flags), 64'(efl));
        if (release_out) begin
            out_ready = 1;
            @(negedge clk);
            out_ready = 0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        bit          saw_valid;
        // Reset state
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.result", 64'(result), 64'd0);
        chk("rst.result_hi", 64'(result_hi), 64'd0);
        chk("rst.flags", 64'(flags), 64'd0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        chk("rst.in_ready_after_release", 64'(in_ready), 64'd1);

        // Directed boundary operations
        run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 1);
        run_op("mul_iter", 4'b0010, 32'h0001_0000, 32'h0001_0000, 1);
        run_op("mod_100_7", 4'b0011, 32'd100, 32'd7, 1);
        run_op("mod_by_zero", 4'b0011, 32'd5, 32'd0, 1);
        run_op("illegal", 4'b1111, 32'h1234_5678, 32'h9, 1);
        run_op("cat", 4'b0101, 32'h1234_ABCD, 32'h5678_EF01, 1);
        run_op("sub_borrow", 4'b0001, 32'd3, 32'd5, 1);
        run_op("gt", 4'b0111, 32'd9, 32'd4, 1);
        run_op("eq", 4'b0110, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1);
        run_op("srl_upper_ignored", 4'b1000, 32'h8000_0000, 32'hFFFF_FFE4, 1);

        // Back-pressure then back-to-back acceptance
        run_op("hold_add", 4'b0000, 32'd5, 32'd6, 0);
        held = result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold.result", 64'(result), 64'(held));
            chk("hold.out_valid", 64'(out_valid), 64'd1);
            chk("hold.in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1; in_valid = 1; opcode = 4'b1001; operand_a = 32'd1; operand_b = 32'd31;
        #1;
        chk("b2b.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 0; out_ready = 0;
        chk("b2b.out_valid", 64'(out_valid), 64'd1);
        chk("b2b.result", 64'(result), 64'h8000_0000);
        chk("b2b.flags", 64'(flags), 64'b1000);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;

        // Reset in the middle of a MOD
        @(negedge clk);
        in_valid = 1; opcode = 4'b0011; operand_a = 32'd100; operand_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        rst_n = 0;
        #1;
        chk("abort.out_valid", 64'(out_valid), 64'd0);
        chk("abort.result", 64'(result), 64'd0);
        chk("abort.flags", 64'(flags), 64'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        chk("abort.in_ready", 64'(in_ready), 64'd1);
        saw_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
        end
        chk("abort.no_result", 64'(saw_valid), 64'd0);

        // Randomized operations against the model
        for (int i = 0; i < 30; i++) begin
            logic [3:0]  rop;
            logic [31:0] ra, rb;
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = (($urandom % 4) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            run_op("rand", rop, ra, rb, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_alu.md
PIPELINED_ALU -- requirements
Module: pipelined_alu

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width; legal values even, 4..64.
REQ-002 SHALL have parameter ITER_MUL, default 1; 1 = iterative shift-add multiply, 0 = single-cycle multiply.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port opcode  input  4  operation select.
REQ-008 SHALL have port operand_a / operand_b  input  N  operands, unsigned.
REQ-009 SHALL have port out_valid  output  1  result held valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  N  low result word.
REQ-012 SHALL have port result_hi  output  N  high product word (MUL), else 0.
REQ-013 SHALL have port flags  output  4  {negative, zero, carry, error}.

Function
REQ-014 SHALL accept a request on a clk edge when in_valid and in_ready are both 1; operands and opcode registered at acceptance.
REQ-015 SHALL implement opcodes: 0000 ADD, 0001 SUB (A-B), 0010 MUL, 0011 MOD (A mod B), 0100 AND, 0101 CAT {A[N/2-1:0],B[N/2-1:0]}, 0110 EQ, 0111 GT (unsigned), 1000 SRL, 1001 SLL; 1010-1111 illegal.
REQ-016 SHALL produce EQ/GT as 1 or 0 zero-extended to N bits.
REQ-017 SHALL shift by operand_b[$clog2(N)-1:0]; upper bits of operand_b ignored.
REQ-018 SHALL use FSM states IDLE, BUSY, DONE.
REQ-019 SHALL transition IDLE->DONE on accepting a single-cycle op (latency 1 cycle to out_valid).
REQ-020 SHALL transition IDLE->BUSY on accepting MOD, or MUL with ITER_MUL=1; BUSY lasts exactly N cycles, then DONE (latency N+1).
REQ-021 SHALL hold result, result_hi, flags, out_valid stable in DONE until out_ready=1.
REQ-022 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-023 SHALL, in DONE with out_ready=1 and in_valid=1, accept the new request in the same cycle (back-to-back, no bubble); with in_valid=0, go to IDLE.
REQ-024 SHALL ignore in_valid in BUSY (in_ready=0).
REQ-025 SHALL set carry = ADD carry-out, SUB borrow (A<B), MUL (result_hi!=0); 0 otherwise.
REQ-026 SHALL set zero = (result==0), negative = result[N-1], for every opcode.
REQ-027 SHALL, on MOD with operand_b==0, return result=operand_a and error=1, still with latency N+1.
REQ-028 SHALL, on illegal opcode, return result=0, error=1, latency 1.

Reset
REQ-029 SHALL, on rst_n low, immediately force state=IDLE, out_valid=0, result=0, result_hi=0, flags=0, iteration counter=0.
REQ-030 SHALL abort any BUSY operation on reset mid-operation; no result is delivered.
REQ-031 SHALL assert in_ready=1 on the first clk edge after rst_n deasserts.

Structure
REQ-032 SHALL place opcode enum, FSM state enum and flag bit-index constants in shared package alu_pkg.
REQ-033 SHALL implement MUL (shift-add) and MOD (restoring division) in sub-module alu_iter_unit with start/done and N-cycle count.

Verification
REQ-034 SHALL verify ADD 0xFFFFFFFF+0x00000001 -> result 0, flags zero=1 carry=1, out_valid 1 cycle after accept.
REQ-035 SHALL verify MUL 0x00010000*0x00010000 (ITER_MUL=1) -> result 0, result_hi 0x00000001, carry=1, out_valid 33 cycles after accept.
REQ-036 SHALL verify MOD 100 mod 7 -> 2; MOD 5 mod 0 -> result 5, error=1.
REQ-037 SHALL verify out_ready held 0 for 5 cycles -> result stable, in_ready=0; then out_ready=1 with in_valid=1 (SLL 1<<31) -> accepted same cycle, next result 0x80000000, negative=1.
REQ-038 SHALL verify rst_n pulsed low during BUSY cycle 10 of MOD -> out_valid never asserts, outputs 0, in_ready=1 after release.
REQ-039 SHALL verify opcode 1111 -> result 0, error=1; CAT 0x1234ABCD,0x5678EF01 -> 0xABCDEF01.
